// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM states, IR field positions and helpers for the 16-bit CPU control path.
package cpu_pkg;

    localparam int unsigned IR_W   = 16;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned OPC_W  = 3;
    localparam int unsigned IMM_W  = 7;
    localparam int unsigned CNT_W  = 16;

    // IR field bit positions
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 13;
    localparam int unsigned RD_MSB  = 12;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned RS_MSB  = 9;
    localparam int unsigned RS_LSB  = 7;
    localparam int unsigned RT_MSB  = 6;
    localparam int unsigned RT_LSB  = 4;
    localparam int unsigned IMM_MSB = 6;
    localparam int unsigned IMM_LSB = 0;

    // Arithmetic opcodes double as the ALU operation codes.
    localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADDI = 3'b010;
    localparam logic [OPC_W-1:0] OP_SUBI = 3'b011;
    localparam logic [OPC_W-1:0] OP_BEQZ = 3'b100;
    localparam logic [OPC_W-1:0] OP_NOP5 = 3'b101;
    localparam logic [OPC_W-1:0] OP_NOP6 = 3'b110;
    localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    function automatic logic [IR_W-1:0] sign_extend7(input logic [IMM_W-1:0] imm);
        return {{(IR_W - IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational instruction decoder: splits IR into register fields, ALU controls and class flags.
module cpu_instr_decode
    import cpu_pkg::*;
(
    input  logic [IR_W-1:0]   ir,
    output logic [REG_AW-1:0] rs_c,
    output logic [REG_AW-1:0] rt_c,
    output logic [REG_AW-1:0] rd_c,
    output logic [OPC_W-1:0]  alu_opcode_c,
    output logic              alu_b_sel_c,
    output logic [IR_W-1:0]   imm_out_c,
    output logic              is_wb_c,
    output logic              is_branch_c,
    output logic              is_halt_c
);

    logic [OPC_W-1:0] op;

    always_comb begin
        op           = ir[OP_MSB:OP_LSB];
        rs_c         = ir[RS_MSB:RS_LSB];
        rt_c         = ir[RT_MSB:RT_LSB];
        rd_c         = ir[RD_MSB:RD_LSB];
        imm_out_c    = sign_extend7(ir[IMM_MSB:IMM_LSB]);
        alu_opcode_c = OP_ADD;
        alu_b_sel_c  = 1'b0;
        is_wb_c      = 1'b0;
        is_branch_c  = 1'b0;
        is_halt_c    = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_opcode_c = op;
                is_wb_c      = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                alu_opcode_c = op;
                alu_b_sel_c  = 1'b1;
                is_wb_c      = 1'b1;
            end
            // Branch compares rs against zero through a subtract with b = 0.
            OP_BEQZ: begin
                alu_opcode_c = OP_SUB;
                alu_b_sel_c  = 1'b1;
                is_branch_c  = 1'b1;
            end
            OP_HALT: is_halt_c = 1'b1;
            OP_NOP5, OP_NOP6: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer owning PC, branch decision and HALT.
// Optional retired-instruction counter enabled by CPU_CTRL_PERF_CNT_EN.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [IR_W-1:0]   imem_rdata,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    output logic [REG_AW-1:0] rf_waddr,
    output logic              rf_we,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic              alu_b_sel,
    output logic [IR_W-1:0]   imm_out,
    input  logic              alu_zero,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_count
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic              zero_q, zero_d;
    logic              active;

    logic              imem_req_q, imem_req_d;
    logic [REG_AW-1:0] rf_raddr_a_q, rf_raddr_a_d;
    logic [REG_AW-1:0] rf_raddr_b_q, rf_raddr_b_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic              rf_we_q, rf_we_d;
    logic [OPC_W-1:0]  alu_opcode_q, alu_opcode_d;
    logic              alu_b_sel_q, alu_b_sel_d;
    logic [IR_W-1:0]   imm_out_q, imm_out_d;
    logic              halted_q, halted_d;

    logic [REG_AW-1:0] rs_c, rt_c, rd_c;
    logic [OPC_W-1:0]  alu_opcode_c;
    logic              alu_b_sel_c;
    logic [IR_W-1:0]   imm_c;
    logic              is_wb_c, is_branch_c, is_halt_c;
    logic [PC_W-1:0]   pc_inc_c, pc_branch_c;

    // Decoding ir_d lets the registered controls be valid on the first DECODE cycle.
    cpu_instr_decode u_decode (
        .ir           (ir_d),
        .rs_c         (rs_c),
        .rt_c         (rt_c),
        .rd_c         (rd_c),
        .alu_opcode_c (alu_opcode_c),
        .alu_b_sel_c  (alu_b_sel_c),
        .imm_out_c    (imm_c),
        .is_wb_c      (is_wb_c),
        .is_branch_c  (is_branch_c),
        .is_halt_c    (is_halt_c)
    );

    assign pc_inc_c    = pc_q + PC_W'(1);
    assign pc_branch_c = pc_inc_c + PC_W'($signed(imm_c));

    always_comb begin
        ir_d = ir_q;
        if (imem_req_q && imem_ack) begin
            ir_d = imem_rdata;
        end
    end

    // Next-state, PC update and registered-output precompute.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE, ST_HALT: if (start) state_d = ST_FETCH;
            ST_FETCH:         if (imem_ack) state_d = ST_DECODE;
            ST_DECODE:        state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                zero_d  = alu_zero;
                state_d = is_halt_c ? ST_HALT : ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                pc_d    = (is_branch_c && zero_q) ? pc_branch_c : pc_inc_c;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        active       = (state_d == ST_DECODE) || (state_d == ST_EXECUTE) ||
                       (state_d == ST_WRITEBACK);
        imem_req_d   = (state_d == ST_FETCH);
        rf_raddr_a_d = active ? rs_c : '0;
        rf_raddr_b_d = active ? rt_c : '0;
        rf_waddr_d   = active ? rd_c : '0;
        alu_opcode_d = active ? alu_opcode_c : '0;
        alu_b_sel_d  = active ? alu_b_sel_c : 1'b0;
        imm_out_d    = (active && !((state_d == ST_EXECUTE) && is_branch_c)) ? imm_c : '0;
        rf_we_d      = (state_d == ST_WRITEBACK) && is_wb_c;
        halted_d     = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            zero_q       <= 1'b0;
            imem_req_q   <= 1'b0;
            rf_raddr_a_q <= '0;
            rf_raddr_b_q <= '0;
            rf_waddr_q   <= '0;
            rf_we_q      <= 1'b0;
            alu_opcode_q <= '0;
            alu_b_sel_q  <= 1'b0;
            imm_out_q    <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            zero_q       <= zero_d;
            imem_req_q   <= imem_req_d;
            rf_raddr_a_q <= rf_raddr_a_d;
            rf_raddr_b_q <= rf_raddr_b_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_we_q      <= rf_we_d;
            alu_opcode_q <= alu_opcode_d;
            alu_b_sel_q  <= alu_b_sel_d;
            imm_out_q    <= imm_out_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign rf_raddr_a = rf_raddr_a_q;
    assign rf_raddr_b = rf_raddr_b_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_we      = rf_we_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_b_sel  = alu_b_sel_q;
    assign imm_out    = imm_out_q;
    assign halted     = halted_q;

`ifdef CPU_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    // Every WRITEBACK exit retires one instruction; HALT never reaches WRITEBACK.
    always_comb begin
        retired_d = retired_q;
        if (state_q == ST_WRITEBACK) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_count = retired_q;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: instruction-level reference model with randomized programs.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [2:0]  rf_raddr_a;
    logic [2:0]  rf_raddr_b;
    logic [2:0]  rf_waddr;
    logic        rf_we;
    logic [2:0]  alu_opcode;
    logic        alu_b_sel;
    logic [15:0] imm_out;
    logic        alu_zero;
    logic        halted;
    logic [15:0] retired_count;

    always #5 clk = ~clk;

    cpu_control_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .rf_raddr_a    (rf_raddr_a),
        .rf_raddr_b    (rf_raddr_b),
        .rf_waddr      (rf_waddr),
        .rf_we         (rf_we),
        .alu_opcode    (alu_opcode),
        .alu_b_sel     (alu_b_sel),
        .imm_out       (imm_out),
        .alu_zero      (alu_zero),
        .halted        (halted),
        .retired_count (retired_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_pc    = 0;   // architectural PC of the reference model
    int m_ret   = 0;   // retired instructions seen by the model

    function automatic int exp_ret();
`ifdef CPU_CTRL_PERF_CNT_EN
        return m_ret;
`else
        return 0;
`endif
    endfunction

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one instruction from a FETCH-state negedge; ends at the next FETCH (or in HALT).
    task automatic step_instr(input logic [15:0] w, input int dly, input logic z, input logic poke);
        int op, rd, rs, rt, imm, simm;
        logic [15:0] eimm;
        op   = int'(w) / 8192;
        rd   = (int'(w) / 1024) % 8;
        rs   = (int'(w) / 128) % 8;
        rt   = (int'(w) / 16) % 8;
        imm  = int'(w) % 128;
        simm = (imm >= 64) ? imm - 128 : imm;
        eimm = 16'(simm);

        for (int i = 0; i <= dly; i++) begin
            n_tests++;
            if (imem_req !== 1'b1 || imem_addr !== 16'(m_pc)) begin
                n_fail++;
                $display("FAIL fetch_req: req=%0b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, 16'(m_pc));
            end
            imem_ack   = (i == dly);
            imem_rdata = (i == dly) ? w : 16'($urandom);
            @(negedge clk);
        end
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        alu_zero   = z;
        start      = poke;

        n_tests++;
        if (imem_req !== 1'b0 || rf_we !== 1'b0 || rf_raddr_a !== 3'(rs) ||
            rf_raddr_b !== 3'(rt) || imm_out !== eimm) begin
            n_fail++;
            $display("FAIL decode_fields w=%h: req=%0b we=%0b a=%0d b=%0d imm=%h, expected 0 0 %0d %0d %h",
                     w, imem_req, rf_we, rf_raddr_a, rf_raddr_b, imm_out, rs, rt, eimm);
        end
        if (op <= 4) begin
            n_tests++;
            if (alu_opcode !== 3'((op == 4) ? 1 : op) || alu_b_sel !== 1'(op >= 2)) begin
                n_fail++;
                $display("FAIL decode_alu w=%h: opc=%0d bsel=%0b, expected opc=%0d bsel=%0b",
                         w, alu_opcode, alu_b_sel, (op == 4) ? 1 : op, op >= 2);
            end
        end
        @(negedge clk);
        start = 1'b0;

        n_tests++;
        if (rf_we !== 1'b0 || rf_raddr_a !== 3'(rs) || rf_raddr_b !== 3'(rt) ||
            imm_out !== ((op == 4) ? 16'h0000 : eimm)) begin
            n_fail++;
            $display("FAIL execute w=%h: we=%0b a=%0d b=%0d imm=%h", w, rf_we, rf_raddr_a, rf_raddr_b, imm_out);
        end
        @(negedge clk);

        if (op == 7) begin
            n_tests++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || rf_we !== 1'b0 ||
                imem_addr !== 16'(m_pc) || retired_count !== 16'(exp_ret())) begin
                n_fail++;
                $display("FAIL halt_entry: halted=%0b req=%0b we=%0b addr=%h ret=%0d, expected 1 0 0 %h %0d",
                         halted, imem_req, rf_we, imem_addr, retired_count, 16'(m_pc), exp_ret());
            end
        end else begin
            n_tests++;
            if (rf_we !== 1'(op < 4) || halted !== 1'b0 || imem_req !== 1'b0 ||
                rf_raddr_a !== 3'(rs) || rf_raddr_b !== 3'(rt)) begin
                n_fail++;
                $display("FAIL writeback w=%h: we=%0b halted=%0b req=%0b a=%0d b=%0d, expected we=%0b",
                         w, rf_we, halted, imem_req, rf_raddr_a, rf_raddr_b, op < 4);
            end
            if (op < 4) begin
                n_tests++;
                if (rf_waddr !== 3'(rd) || alu_opcode !== 3'(op)) begin
                    n_fail++;
                    $display("FAIL wb_dest w=%h: waddr=%0d opc=%0d, expected %0d %0d", w, rf_waddr, alu_opcode, rd, op);
                end
            end
            if (op == 4 && z) m_pc = (m_pc + 1 + simm) & 32'hFFFF;
            else              m_pc = (m_pc + 1) & 32'hFFFF;
            m_ret = (m_ret + 1) & 32'hFFFF;
            @(negedge clk);
            n_tests++;
            if (imem_req !== 1'b1 || rf_we !== 1'b0 || imem_addr !== 16'(m_pc) ||
                retired_count !== 16'(exp_ret())) begin
                n_fail++;
                $display("FAIL next_fetch w=%h: req=%0b we=%0b addr=%h ret=%0d, expected 1 0 %h %0d",
                         w, imem_req, rf_we, imem_addr, retired_count, 16'(m_pc), exp_ret());
            end
        end
    endtask

    // Walks the PC to a target with taken BEQZ hops of at most +/-64.
    task automatic goto_pc(input int tgt);
        int d, guard;
        logic [15:0] w;
        guard = 0;
        while (m_pc != tgt && guard < 3000) begin
            d = (tgt - (m_pc + 1)) & 32'hFFFF;
            if (d >= 32768) d -= 65536;
            if (d > 63)  d = 63;
            if (d < -64) d = -64;
            w = 16'h8000 | 16'(d & 127);
            step_instr(w, 0, 1'b1, 1'b0);
            guard++;
        end
        if (guard >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL goto_pc: target %h not reached, model pc %h", 16'(tgt), 16'(m_pc));
        end
    endtask

    function automatic logic [15:0] rand_word(input int op);
        return 16'(op * 8192) | 16'($urandom & 32'h1FFF);
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0; alu_zero = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({imem_req, imem_addr, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, alu_opcode,
             alu_b_sel, imm_out, halted, retired_count} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%0b addr=%h we=%0b opc=%0d imm=%h halted=%0b ret=%0d, expected all 0",
                     imem_req, imem_addr, rf_we, alu_opcode, imm_out, halted, retired_count);
        end
        rst = 1'b0; m_pc = 0; m_ret = 0;
        imem_ack = 1'b1; imem_rdata = 16'hFFFF;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        n_tests++;
        if (imem_req !== 1'b0 || halted !== 1'b0 || rf_we !== 1'b0 || imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL idle_hold: req=%0b halted=%0b we=%0b addr=%h, expected 0 0 0 0000",
                     imem_req, halted, rf_we, imem_addr);
        end
    endtask

    task automatic test_add();
        start_pulse();
        step_instr(16'h0530, 0, 1'b0, 1'b0);
        n_tests++;
        if (imem_addr !== 16'h0001) begin
            n_fail++;
            $display("FAIL add_pc: addr=%h, expected 0001", imem_addr);
        end
    endtask

    task automatic test_addi();
        step_instr(16'h527F, 0, 1'($urandom), 1'b0);
    endtask

    task automatic test_branch();
        goto_pc(10);
        step_instr(16'h8283, 0, 1'b1, 1'b0);
        n_tests++;
        if (imem_addr !== 16'd14) begin
            n_fail++;
            $display("FAIL beqz_taken: addr=%0d, expected 14", imem_addr);
        end
        step_instr(16'h807B, 0, 1'b1, 1'b0);
        step_instr(16'h8283, 0, 1'b0, 1'b0);
        n_tests++;
        if (imem_addr !== 16'd11) begin
            n_fail++;
            $display("FAIL beqz_not_taken: addr=%0d, expected 11", imem_addr);
        end
    endtask

    task automatic test_ack_delay();
        step_instr(rand_word($urandom_range(0, 3)), 3, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            step_instr(rand_word($urandom_range(0, 6)), $urandom_range(0, 2),
                       1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF);
        step_instr(16'hA000, 0, 1'b0, 1'b0);
        n_tests++;
        if (imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL pc_wrap: addr=%h, expected 0000", imem_addr);
        end
    endtask

    task automatic test_halt();
        goto_pc(7);
        step_instr(16'hE000, 0, 1'b0, 1'b0);
        imem_ack = 1'b1; imem_rdata = 16'($urandom);
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        n_tests++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 16'd7) begin
            n_fail++;
            $display("FAIL halt_hold: halted=%0b req=%0b addr=%0d, expected 1 0 7", halted, imem_req, imem_addr);
        end
        start_pulse();
        step_instr(16'hE000, 1, 1'b0, 1'b0);
        start_pulse();
        step_instr(16'hC000, 0, 1'b0, 1'b0);
        n_tests++;
        if (imem_addr !== 16'd8 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_restart: addr=%0d halted=%0b, expected 8 0", imem_addr, halted);
        end
    endtask

    task automatic test_reset_mid();
        imem_ack = 1'b1; imem_rdata = 16'h0530;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (rf_we !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_we: we=%0b, expected 1", rf_we);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (rf_we !== 1'b0 || imem_addr !== 16'h0000 || imem_req !== 1'b0 ||
            halted !== 1'b0 || retired_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid: we=%0b addr=%h req=%0b halted=%0b ret=%0d, expected all 0",
                     rf_we, imem_addr, imem_req, halted, retired_count);
        end
        @(negedge clk);
        rst = 1'b0; m_pc = 0; m_ret = 0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b0 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: req=%0b we=%0b, expected 0 0", imem_req, rf_we);
        end
    endtask

    task automatic test_perf();
        start_pulse();
        for (int k = 0; k < 5; k++) begin
            step_instr(rand_word($urandom_range(0, 6)), 0, 1'($urandom), 1'b0);
        end
        n_tests++;
`ifdef CPU_CTRL_PERF_CNT_EN
        if (retired_count !== 16'd5) begin
            n_fail++;
            $display("FAIL perf_count: ret=%0d, expected 5", retired_count);
        end
`else
        if (retired_count !== 16'd0) begin
            n_fail++;
            $display("FAIL perf_count: ret=%0d, expected 0", retired_count);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; m_pc = 0; m_ret = 0;
        n_tests++;
        if (retired_count !== 16'd0 || imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL perf_reset: ret=%0d addr=%h, expected 0 0000", retired_count, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_branch();
        test_ack_delay();
        test_random();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
